// File: rtl/tag_retire_queue.sv
// tag_retire_queue: in-order retirement queue on the rename-tag return path.
// Entries are recorded at dispatch in program order, marked complete by CDB
// broadcasts, and retired strictly from the head. Each retirement returns its
// tag to the free list and presents the register-commit information.
module tag_retire_queue #(
    parameter int DEPTH = 32
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       flush_valid,
    input  logic       dispatch_valid,
    input  logic [4:0] dispatch_tag,
    input  logic [4:0] dispatch_rd,
    input  logic       dispatch_rd_valid,
    input  logic       cdb_valid,
    input  logic [4:0] cdb_tag,
    input  logic       retire_ready,
    output logic       retire_valid,
    output logic [4:0] retire_tag,
    output logic [4:0] retire_rd,
    output logic       retire_rd_valid,
    output logic       queue_empty,
    output logic       queue_full,
    output logic [5:0] count
);

    // Pointers carry a wrap bit in [5]; entries are indexed by [4:0].
    logic [5:0]       wp_q, wp_d;
    logic [5:0]       rp_q, rp_d;
    logic [4:0]       tag_q [DEPTH];
    logic [4:0]       tag_d [DEPTH];
    logic [4:0]       rd_q  [DEPTH];
    logic [4:0]       rd_d  [DEPTH];
    logic [DEPTH-1:0] rdv_q, rdv_d;
    logic [DEPTH-1:0] done_q, done_d;

    logic [5:0] count_s;
    logic       empty_s;
    logic       full_s;
    logic       retire_valid_s;
    logic       retire_fire_s;

    // True when slot idx lies inside the occupied window starting at head.
    function automatic logic in_window(input logic [4:0] idx,
                                       input logic [4:0] head,
                                       input logic [5:0] cnt);
        logic [4:0] off;
        off = idx - head;
        return ({1'b0, off} < cnt);
    endfunction

    // Occupancy status and head-retirement qualification from current state.
    always_comb begin
        count_s        = wp_q - rp_q;
        empty_s        = (wp_q == rp_q);
        full_s         = (wp_q[5] != rp_q[5]) && (wp_q[4:0] == rp_q[4:0]);
        retire_valid_s = !empty_s && done_q[rp_q[4:0]] && !flush_valid;
        retire_fire_s  = retire_valid_s && retire_ready;
    end

    assign retire_valid    = retire_valid_s;
    assign retire_tag      = tag_q[rp_q[4:0]];
    assign retire_rd       = rd_q[rp_q[4:0]];
    assign retire_rd_valid = rdv_q[rp_q[4:0]];
    assign queue_empty     = empty_s;
    assign queue_full      = full_s;
    assign count           = count_s;

    // Next-state: flush dominates; otherwise CDB marking, dispatch, retire.
    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        tag_d  = tag_q;
        rd_d   = rd_q;
        rdv_d  = rdv_q;
        done_d = done_q;
        if (flush_valid) begin
            wp_d   = 6'd0;
            rp_d   = 6'd0;
            done_d = {DEPTH{1'b0}};
        end else begin
            // Only occupied entries may be marked; the slot being written
            // this cycle is outside the window, so a same-cycle CDB for the
            // new tag is ignored.
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_valid && in_window(5'(i), rp_q[4:0], count_s) &&
                    (tag_q[i] == cdb_tag)) begin
                    done_d[i] = 1'b1;
                end else begin
                    done_d[i] = done_q[i];
                end
            end
            // Fullness is judged on current state; a same-cycle retire
            // does not make room.
            if (dispatch_valid && !full_s) begin
                tag_d[wp_q[4:0]]  = dispatch_tag;
                rd_d[wp_q[4:0]]   = dispatch_rd;
                rdv_d[wp_q[4:0]]  = dispatch_rd_valid;
                done_d[wp_q[4:0]] = 1'b0;
                wp_d              = wp_q + 6'd1;
            end else begin
                wp_d = wp_q;
            end
            if (retire_fire_s) begin
                rp_d = rp_q + 6'd1;
            end else begin
                rp_d = rp_q;
            end
        end
    end

    // State registers with asynchronous clear of pointers and all entries.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wp_q   <= 6'd0;
            rp_q   <= 6'd0;
            rdv_q  <= {DEPTH{1'b0}};
            done_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= 5'd0;
                rd_q[i]  <= 5'd0;
            end
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            rdv_q  <= rdv_d;
            done_q <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
                rd_q[i]  <= rd_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tag_retire_queue.sv
// Directed self-checking bench for tag_retire_queue.
module tb_tag_retire_queue;

    logic       clock = 1'b0;
    logic       nreset;
    logic       flush_valid;
    logic       dispatch_valid;
    logic [4:0] dispatch_tag;
    logic [4:0] dispatch_rd;
    logic       dispatch_rd_valid;
    logic       cdb_valid;
    logic [4:0] cdb_tag;
    logic       retire_ready;
    logic       retire_valid;
    logic [4:0] retire_tag;
    logic [4:0] retire_rd;
    logic       retire_rd_valid;
    logic       queue_empty;
    logic       queue_full;
    logic [5:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tag_retire_queue dut (
        .clock             (clock),
        .nreset            (nreset),
        .flush_valid       (flush_valid),
        .dispatch_valid    (dispatch_valid),
        .dispatch_tag      (dispatch_tag),
        .dispatch_rd       (dispatch_rd),
        .dispatch_rd_valid (dispatch_rd_valid),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .retire_ready      (retire_ready),
        .retire_valid      (retire_valid),
        .retire_tag        (retire_tag),
        .retire_rd         (retire_rd),
        .retire_rd_valid   (retire_rd_valid),
        .queue_empty       (queue_empty),
        .queue_full        (queue_full),
        .count             (count)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    task automatic idle();
        flush_valid       = 1'b0;
        dispatch_valid    = 1'b0;
        dispatch_tag      = 5'd0;
        dispatch_rd       = 5'd0;
        dispatch_rd_valid = 1'b0;
        cdb_valid         = 1'b0;
        cdb_tag           = 5'd0;
        retire_ready      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_flush();
        flush_valid = 1'b1;
        tick();
        flush_valid = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        idle();
        #1;
        total_cnt++; if (retire_valid !== 1'b0) $display("FAIL reset_rv: got %0d expected 0", retire_valid); else pass_cnt++;
        total_cnt++; if (queue_empty !== 1'b1) $display("FAIL reset_empty: got %0d expected 1", queue_empty); else pass_cnt++;
        total_cnt++; if (queue_full !== 1'b0) $display("FAIL reset_full: got %0d expected 0", queue_full); else pass_cnt++;
        total_cnt++; if (count !== 6'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
        total_cnt++; if (retire_tag !== 5'd0 || retire_rd !== 5'd0 || retire_rd_valid !== 1'b0)
            $display("FAIL reset_head: got tag %0d rd %0d rdv %0d expected 0 0 0", retire_tag, retire_rd, retire_rd_valid);
        else pass_cnt++;
        #10;
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 3; i++) begin
            dispatch_valid = 1'b1; dispatch_tag = 5'(i); dispatch_rd = 5'(i + 3); dispatch_rd_valid = 1'b1;
            tick();
        end
        dispatch_valid = 1'b0;
        total_cnt++; if (count !== 6'd3) $display("FAIL inorder_count3: got %0d expected 3", count); else pass_cnt++;
        retire_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 5'd1;
        tick();
        cdb_valid = 1'b0;
        total_cnt++; if (retire_valid !== 1'b0 || count !== 6'd3)
            $display("FAIL inorder_young_wait: got rv %0d count %0d expected 0 3", retire_valid, count);
        else pass_cnt++;
        cdb_valid = 1'b1; cdb_tag = 5'd0;
        tick();
        cdb_valid = 1'b0;
        total_cnt++; if (retire_valid !== 1'b1 || retire_tag !== 5'd0 || retire_rd !== 5'd3 || retire_rd_valid !== 1'b1)
            $display("FAIL inorder_ret0: got rv %0d tag %0d rd %0d expected 1 0 3", retire_valid, retire_tag, retire_rd);
        else pass_cnt++;
        tick();
        total_cnt++; if (retire_valid !== 1'b1 || retire_tag !== 5'd1 || retire_rd !== 5'd4 || count !== 6'd2)
            $display("FAIL inorder_ret1: got rv %0d tag %0d rd %0d count %0d expected 1 1 4 2", retire_valid, retire_tag, retire_rd, count);
        else pass_cnt++;
        tick();
        total_cnt++; if (retire_valid !== 1'b0 || retire_tag !== 5'd2 || count !== 6'd1)
            $display("FAIL inorder_tag2_wait: got rv %0d tag %0d count %0d expected 0 2 1", retire_valid, retire_tag, count);
        else pass_cnt++;
        cdb_valid = 1'b1; cdb_tag = 5'd2;
        tick();
        cdb_valid = 1'b0;
        total_cnt++; if (retire_valid !== 1'b1 || retire_rd !== 5'd5)
            $display("FAIL inorder_ret2: got rv %0d rd %0d expected 1 5", retire_valid, retire_rd);
        else pass_cnt++;
        tick();
        retire_ready = 1'b0;
        total_cnt++; if (queue_empty !== 1'b1 || count !== 6'd0)
            $display("FAIL inorder_drained: got empty %0d count %0d expected 1 0", queue_empty, count);
        else pass_cnt++;
    endtask

    task automatic test_full();
        // Pointers start at 3 here, so 32 increments move both to 35.
        for (int i = 0; i < 32; i++) begin
            dispatch_valid = 1'b1; dispatch_tag = 5'(i); dispatch_rd = 5'(31 - i); dispatch_rd_valid = i[0];
            tick();
        end
        total_cnt++; if (queue_full !== 1'b1 || count !== 6'd32)
            $display("FAIL full_32: got full %0d count %0d expected 1 32", queue_full, count);
        else pass_cnt++;
        dispatch_tag = 5'd7; dispatch_rd = 5'd9;
        tick();
        dispatch_valid = 1'b0;
        total_cnt++; if (count !== 6'd32 || retire_tag !== 5'd0 || retire_rd !== 5'd31)
            $display("FAIL full_drop33: got count %0d tag %0d rd %0d expected 32 0 31", count, retire_tag, retire_rd);
        else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            cdb_valid = 1'b1; cdb_tag = 5'(31 - i);
            tick();
        end
        cdb_valid = 1'b0;
        retire_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            total_cnt++;
            if (retire_valid !== 1'b1 || retire_tag !== 5'(i) || retire_rd !== 5'(31 - i) || retire_rd_valid !== i[0])
                $display("FAIL full_order[%0d]: got rv %0d tag %0d rd %0d rdv %0d expected 1 %0d %0d %0d",
                         i, retire_valid, retire_tag, retire_rd, retire_rd_valid, i, 31 - i, i[0]);
            else pass_cnt++;
            tick();
        end
        retire_ready = 1'b0;
        total_cnt++; if (queue_empty !== 1'b1 || queue_full !== 1'b0 || count !== 6'd0)
            $display("FAIL full_drained: got empty %0d full %0d count %0d expected 1 0 0", queue_empty, queue_full, count);
        else pass_cnt++;
        total_cnt++; if (dut.wp_q !== 6'd35 || dut.rp_q !== 6'd35)
            $display("FAIL full_wrap: got wp %0d rp %0d expected 35 35", dut.wp_q, dut.rp_q);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        dispatch_valid = 1'b1; dispatch_tag = 5'd9; dispatch_rd = 5'd10; dispatch_rd_valid = 1'b0;
        tick();
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd9;
        tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (retire_valid !== 1'b1 || retire_tag !== 5'd9 || retire_rd !== 5'd10 || count !== 6'd1)
                $display("FAIL hold[%0d]: got rv %0d tag %0d rd %0d count %0d expected 1 9 10 1",
                         k, retire_valid, retire_tag, retire_rd, count);
            else pass_cnt++;
            tick();
        end
        retire_ready = 1'b1;
        tick();
        retire_ready = 1'b0;
        total_cnt++; if (count !== 6'd0 || retire_valid !== 1'b0 || queue_empty !== 1'b1)
            $display("FAIL hold_release: got count %0d rv %0d empty %0d expected 0 0 1", count, retire_valid, queue_empty);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_flush();
        for (int i = 0; i < 5; i++) begin
            dispatch_valid = 1'b1; dispatch_tag = 5'(i); dispatch_rd = 5'(i + 1); dispatch_rd_valid = 1'b1;
            tick();
        end
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd0; tick();
        cdb_tag = 5'd1; tick();
        cdb_valid = 1'b0;
        total_cnt++; if (count !== 6'd5 || retire_valid !== 1'b1 || retire_tag !== 5'd0)
            $display("FAIL b2b_setup: got count %0d rv %0d tag %0d expected 5 1 0", count, retire_valid, retire_tag);
        else pass_cnt++;
        dispatch_valid = 1'b1; dispatch_tag = 5'd5; dispatch_rd = 5'd6; retire_ready = 1'b1;
        tick();
        dispatch_valid = 1'b0; retire_ready = 1'b0;
        total_cnt++; if (count !== 6'd5 || retire_tag !== 5'd1 || retire_valid !== 1'b1)
            $display("FAIL b2b_count5: got count %0d tag %0d rv %0d expected 5 1 1", count, retire_tag, retire_valid);
        else pass_cnt++;
        do_flush();
        for (int i = 0; i < 32; i++) begin
            dispatch_valid = 1'b1; dispatch_tag = 5'(i); dispatch_rd = 5'(i);
            tick();
        end
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd0; tick();
        cdb_valid = 1'b0;
        total_cnt++; if (queue_full !== 1'b1 || retire_valid !== 1'b1)
            $display("FAIL b2b_full_setup: got full %0d rv %0d expected 1 1", queue_full, retire_valid);
        else pass_cnt++;
        dispatch_valid = 1'b1; dispatch_tag = 5'd20; dispatch_rd = 5'd20; retire_ready = 1'b1;
        tick();
        dispatch_valid = 1'b0; retire_ready = 1'b0;
        total_cnt++; if (count !== 6'd31 || queue_full !== 1'b0 || retire_tag !== 5'd1 || retire_valid !== 1'b0)
            $display("FAIL b2b_full_drop: got count %0d full %0d tag %0d rv %0d expected 31 0 1 0",
                     count, queue_full, retire_tag, retire_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 10; i++) begin
            dispatch_valid = 1'b1; dispatch_tag = 5'(i); dispatch_rd = 5'(i);
            tick();
        end
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd0; tick();
        cdb_tag = 5'd1; tick();
        cdb_valid = 1'b0;
        total_cnt++; if (retire_valid !== 1'b1 || count !== 6'd10)
            $display("FAIL flush_setup: got rv %0d count %0d expected 1 10", retire_valid, count);
        else pass_cnt++;
        flush_valid = 1'b1; retire_ready = 1'b1;
        #1;
        total_cnt++; if (retire_valid !== 1'b0) $display("FAIL flush_rv_low: got %0d expected 0", retire_valid); else pass_cnt++;
        tick();
        flush_valid = 1'b0;
        total_cnt++; if (count !== 6'd0 || queue_empty !== 1'b1)
            $display("FAIL flush_empty: got count %0d empty %0d expected 0 1", count, queue_empty);
        else pass_cnt++;
        cdb_valid = 1'b1; cdb_tag = 5'd0;
        tick();
        cdb_valid = 1'b0;
        total_cnt++; if (retire_valid !== 1'b0 || count !== 6'd0)
            $display("FAIL flush_stale_cdb: got rv %0d count %0d expected 0 0", retire_valid, count);
        else pass_cnt++;
        dispatch_valid = 1'b1; dispatch_tag = 5'd12; dispatch_rd = 5'd12;
        cdb_valid = 1'b1; cdb_tag = 5'd12;
        tick();
        dispatch_valid = 1'b0; cdb_valid = 1'b0;
        total_cnt++; if (retire_valid !== 1'b0 || count !== 6'd1)
            $display("FAIL same_cycle_cdb: got rv %0d count %0d expected 0 1", retire_valid, count);
        else pass_cnt++;
        retire_ready = 1'b0;
        do_flush();
    endtask

    task automatic test_async_reset();
        dispatch_valid = 1'b1; dispatch_tag = 5'd3; dispatch_rd = 5'd7; dispatch_rd_valid = 1'b1;
        tick();
        dispatch_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd3;
        tick();
        cdb_valid = 1'b0;
        total_cnt++; if (retire_valid !== 1'b1 || retire_tag !== 5'd3)
            $display("FAIL areset_setup: got rv %0d tag %0d expected 1 3", retire_valid, retire_tag);
        else pass_cnt++;
        #3;
        nreset = 1'b0;
        #1;
        total_cnt++; if (retire_valid !== 1'b0 || retire_tag !== 5'd0 || retire_rd !== 5'd0 || retire_rd_valid !== 1'b0)
            $display("FAIL areset_head: got rv %0d tag %0d rd %0d rdv %0d expected 0 0 0 0",
                     retire_valid, retire_tag, retire_rd, retire_rd_valid);
        else pass_cnt++;
        total_cnt++; if (queue_empty !== 1'b1 || queue_full !== 1'b0 || count !== 6'd0)
            $display("FAIL areset_status: got empty %0d full %0d count %0d expected 1 0 0", queue_empty, queue_full, count);
        else pass_cnt++;
        retire_ready = 1'b1;
        #2;
        nreset = 1'b1;
        tick();
        tick();
        total_cnt++; if (retire_valid !== 1'b0 || count !== 6'd0 || queue_empty !== 1'b1)
            $display("FAIL areset_after: got rv %0d count %0d empty %0d expected 0 0 1", retire_valid, count, queue_empty);
        else pass_cnt++;
        retire_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_hold();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tag_retire_queue.md
# tag_retire_queue

In-order retirement queue for the out-of-order core; it sits on the return path of the 5-bit rename-tag free list. Each dispatched instruction's tag and destination register are recorded in program order, and common data bus (CDB) broadcasts mark entries complete. Completed entries retire strictly from the head. Each retirement drives the tag back to the free list (`retire_valid`→free-list `wr_en`, `retire_tag`→`tag_in`) and presents the register-commit information.

## Interface
- `DEPTH`, 32: number of entries; fixed at 32 (one per tag); pointers are 6 bits.
- `clock` input 1: single clock, rising edge.
- `nreset` input 1: asynchronous, active-low reset.
- `flush_valid` input 1: synchronous flush; empties the queue.
- `dispatch_valid` input 1: write a new entry at the tail.
- `dispatch_tag` input 5: tag taken from the free list for this instruction.
- `dispatch_rd` input 5: destination register.
- `dispatch_rd_valid` input 1: instruction writes a register.
- `cdb_valid` input 1: completion broadcast.
- `cdb_tag` input 5: tag that completed.
- `retire_ready` input 1: commit side accepts a retirement this cycle.
- `retire_valid` output 1: head entry is complete and retiring.
- `retire_tag` output 5: head tag returned to the free list.
- `retire_rd` output 5: head destination register.
- `retire_rd_valid` output 1: head writes a register; qualified by `retire_valid`.
- `queue_empty` output 1: no valid entries.
- `queue_full` output 1: 32 valid entries.
- `count` output 6: number of valid entries, 0..32.

## Operation
- Storage per entry: tag[4:0], rd[4:0], rd_valid, done. Write pointer `wp[5:0]` and read pointer `rp[5:0]`; entries are indexed by bits [4:0]; bit 5 is the wrap bit.
- `queue_empty = (wp == rp)`; `queue_full = (wp[5] != rp[5]) && (wp[4:0] == rp[4:0])`; `count = wp - rp`, mod 64.
- Dispatch: when `dispatch_valid && !queue_full`, store tag/rd/rd_valid at `wp[4:0]`, clear done, and increment `wp`. Dispatch while full is dropped silently with no state change. Fullness is evaluated on the current state; a retirement in the same cycle does not make room.
- Completion: when `cdb_valid`, every valid entry (between rp and wp) whose tag equals `cdb_tag` gets done set. Tags are unique, so at most one entry matches. A CDB tag matching no valid entry is ignored. A CDB tag equal to the `dispatch_tag` being written in the same cycle does not mark the new entry.
- Retire: `retire_valid = !queue_empty && head.done && !flush_valid`. `retire_tag`, `retire_rd`, and `retire_rd_valid` come combinationally from the head entry. When `retire_valid && retire_ready`, `rp` increments. When `retire_ready` is low, the head holds and outputs stay stable.
- Simultaneous dispatch and retire: both take effect and `count` is unchanged.
- Flush: `wp <= 0`, `rp <= 0`, all done bits cleared, and `retire_valid` forced low in the flush cycle. Flush has priority over dispatch, CDB, and retire in that cycle.
- Reset: `wp`, `rp`, and all entry fields go to 0 immediately and asynchronously. Outputs after reset: `retire_valid` 0, `retire_tag` 0, `retire_rd` 0, `retire_rd_valid` 0, `queue_empty` 1, `queue_full` 0, `count` 0. Reset mid-operation discards all entries; no retirement is emitted.

## Timing
- Dispatch at edge N makes the entry visible (count/empty/full updated) in cycle N+1.
- CDB at edge N sets done, so the earliest `retire_valid` for that entry (if it is the head) is cycle N+1. CDB-to-retire latency is 1 cycle minimum.
- Throughput: one dispatch and one retirement per cycle.
- A younger completed entry waits until all older entries retire; retirement order always equals dispatch order.
- Pointer wrap: after 32 increments, index [4:0] returns to 0 and bit 5 toggles. Full and empty stay distinct across wrap.

## Test plan
- Reset, then dispatch tags 0,1,2 (rd 3,4,5), then CDB tag 1 → no retire. Then CDB tag 0 → retire tag 0 (rd 3) next cycle, then tag 1 in the following cycle. Tag 2 stays until its CDB; count goes 3→2→1.
- Fill with 32 dispatches → `queue_full`=1, count=32. A 33rd dispatch is dropped and count stays 32. Complete and retire all 32 in order → `queue_empty`=1 and the wrap bit has toggled on both pointers.
- Head complete with `retire_ready`=0 for 3 cycles → `retire_valid` held at 1 with `retire_tag` stable and count unchanged. Raise ready → exactly one retirement.
- Dispatch and retire in the same cycle at count 5 → count stays 5. Dispatch while full with a retire in the same cycle → dispatch dropped and count becomes 31.
- 10 entries, some done, then `flush_valid` → `retire_valid` 0 in the flush cycle. Next cycle: count 0 and empty 1, and a stale CDB for a flushed tag causes no retirement.
- Assert `nreset` low asynchronously mid-stream with a pending retirement → outputs go to their reset values without waiting for a clock edge, and nothing is retired after release.
